// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a configurable frame format
// (data width, parity mode, stop-bit count) and an input FIFO that lets
// queued words go out as back-to-back frames with no idle gap.
//
// Input handshake: a word is accepted on a rising clock edge where
// tx_valid && tx_ready are both high. tx_ready depends only on registered
// FIFO occupancy, never on tx_valid. The word is copied into the FIFO on
// that edge, so later changes on tx_data cannot affect it.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_busy,
    output logic                        tx_serial,
    output logic [2:0]                  dbg_state
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    // Sized for twice the bit period so a double stop bit counts in one pass
    localparam int CW  = $clog2(CLKS_PER_BIT * 2);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [AW:0]   FULL_COUNT = AW1'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    // Transmit engine
    state_t               r_state;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_busy;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_nonempty  = (r_count != '0);
    assign w_frame_end = (r_state == S_STOP) && (r_baud == STOP_LAST);
    // Pop when idle, or on the last stop-bit cycle so the next start bit follows directly
    assign w_pop       = w_nonempty && ((r_state == S_IDLE) || w_frame_end);
    assign w_push      = tx_valid && tx_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign tx_ready   = (r_count != FULL_COUNT);
    assign fifo_count = r_count;
    assign tx_busy    = r_busy;
    assign tx_serial  = r_serial;
    assign dbg_state  = r_state;

    // FIFO data array: written on accepted pushes; reset discards contents via the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer with registered line and busy outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= ^w_head;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                        r_baud   <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_serial <= r_shift[0];
                        r_state  <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud <= '0;
                        if (r_bit == DATA_LAST) begin
                            if (PARITY != 0) begin
                                r_serial <= r_parity ^ PAR_ODD;
                                r_state  <= S_PARITY;
                            end else begin
                                r_serial <= 1'b1;
                                r_state  <= S_STOP;
                            end
                        end else begin
                            r_bit    <= r_bit + 1'b1;
                            r_shift  <= r_shift >> 1;
                            r_serial <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud   <= '0;
                        r_serial <= 1'b1;
                        r_state  <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_frame_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift  <= w_head;
                            r_parity <= ^w_head;
                            r_serial <= 1'b0;
                            r_state  <= S_START;
                        end else begin
                            r_serial <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter instances with different frame formats,
// a per-cycle reference model built from frame bit lists, and directed tests.
//   dut 0: 8 data bits, no parity,   1 stop bit
//   dut 1: 7 data bits, even parity, 1 stop bit
//   dut 2: 7 data bits, odd parity,  2 stop bits
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i [3];
    logic [7:0] data_i  [3];
    logic       ready_o [3];
    logic       busy_o  [3];
    logic       ser_o   [3];
    logic [4:0] cnt_o   [3];
    logic [2:0] st_o    [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: queued words and remaining per-cycle line levels
    int unsigned m_q     [3][$];
    logic        m_frame [3][$];
    logic        m_busy  [3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .tx_data(data_i[0]), .tx_valid(valid_i[0]),
        .tx_ready(ready_o[0]), .fifo_count(cnt_o[0]), .tx_busy(busy_o[0]),
        .tx_serial(ser_o[0]), .dbg_state(st_o[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(data_i[1][6:0]), .tx_valid(valid_i[1]),
        .tx_ready(ready_o[1]), .fifo_count(cnt_o[1]), .tx_busy(busy_o[1]),
        .tx_serial(ser_o[1]), .dbg_state(st_o[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset(reset), .tx_data(data_i[2][6:0]), .tx_valid(valid_i[2]),
        .tx_ready(ready_o[2]), .fifo_count(cnt_o[2]), .tx_busy(busy_o[2]),
        .tx_serial(ser_o[2]), .dbg_state(st_o[2]));

    function automatic int cfg_db(input int k);
        return (k == 0) ? 8 : 7;
    endfunction

    function automatic int cfg_par(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic int cfg_sb(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand one word into the line level for every cycle of its frame
    function automatic void build_frame(input int k, input int unsigned w);
        int   ones;
        logic lvl;
        ones = 0;
        for (int j = 0; j < CPB; j++) m_frame[k].push_back(1'b0);
        for (int i = 0; i < cfg_db(k); i++) begin
            lvl = w[i];
            if (lvl) ones++;
            for (int j = 0; j < CPB; j++) m_frame[k].push_back(lvl);
        end
        if (cfg_par(k) != 0) begin
            lvl = (cfg_par(k) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            for (int j = 0; j < CPB; j++) m_frame[k].push_back(lvl);
        end
        for (int j = 0; j < cfg_sb(k) * CPB; j++) m_frame[k].push_back(1'b1);
    endfunction

    // Model update on each rising edge, then compare all outputs shortly after
    always begin : model_and_compare
        logic        can_push;
        logic        exp_ser;
        int unsigned w;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_q[k].delete();
                m_frame[k].delete();
                m_busy[k] = 1'b0;
            end else begin
                can_push = (m_q[k].size() < DEPTH);
                if (m_busy[k]) void'(m_frame[k].pop_front());
                if (m_frame[k].size() == 0) begin
                    if (m_q[k].size() != 0) begin
                        w = m_q[k].pop_front();
                        build_frame(k, w);
                        m_busy[k] = 1'b1;
                    end else begin
                        m_busy[k] = 1'b0;
                    end
                end
                if (valid_i[k] && can_push)
                    m_q[k].push_back(int'(data_i[k]) & ((1 << cfg_db(k)) - 1));
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_ser = m_busy[k] ? m_frame[k][0] : 1'b1;
            check($sformatf("cyc_serial[%0d]", k), 32'(ser_o[k]), 32'(exp_ser));
            check($sformatf("cyc_busy[%0d]", k), 32'(busy_o[k]), 32'(m_busy[k]));
            check($sformatf("cyc_count[%0d]", k), 32'(cnt_o[k]), 32'(m_q[k].size()));
            check($sformatf("cyc_ready[%0d]", k), 32'(ready_o[k]), 32'(m_q[k].size() != DEPTH));
        end
    end

    // Push one word, then record the mid-bit line level of each bit period and the busy length
    task automatic send_capture(input int k, input logic [7:0] w, output int busy_cyc, output logic [11:0] bits);
        int c;
        int guard;
        bits  = '1;
        c     = 0;
        guard = 0;
        @(negedge clk);
        valid_i[k] = 1'b1;
        data_i[k]  = w;
        @(negedge clk);
        valid_i[k] = 1'b0;
        forever begin
            @(negedge clk);
            guard++;
            if (busy_o[k] === 1'b1) begin
                if ((c % CPB) == 2) bits[c / CPB] = ser_o[k];
                c++;
            end else if (c != 0) begin
                break;
            end
            if (guard > 200) begin
                check("capture_timeout", 32'(guard), 32'd200);
                break;
            end
        end
        busy_cyc = c;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((busy_o[k] !== 1'b0 || cnt_o[k] !== 5'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_within_budget[%0d]", k), 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin : stimulus
        int         bc;
        int         c;
        logic [11:0] bits;

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_i[k] = 1'b0;
            data_i[k]  = 8'h00;
        end

        // Reset state, held and released
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(ser_o[0]), 32'd1);
        check("rst_ready", 32'(ready_o[0]), 32'd1);
        check("rst_count", 32'(cnt_o[0]), 32'd0);
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        check("rst_state_idle", 32'(st_o[0]), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_serial", 32'(ser_o[0]), 32'd1);
        check("rel_ready", 32'(ready_o[0]), 32'd1);
        check("rel_count", 32'(cnt_o[0]), 32'd0);
        check("rel_busy", 32'(busy_o[0]), 32'd0);

        // Single 8N1 frame of 0xA5
        send_capture(0, 8'hA5, bc, bits);
        check("a5_bits", 32'(bits[9:0]), 32'(10'b1101001010));
        check("a5_busy_len", 32'(bc), 32'd40);

        // Even parity, 7 data bits: 0x55 has four ones
        send_capture(1, 8'h55, bc, bits);
        check("even_bits", 32'(bits[9:0]), 32'(10'b1010101010));
        check("even_parity_bit", 32'(bits[8]), 32'd0);
        check("even_busy_len", 32'(bc), 32'd40);

        // Odd parity, 7 data bits, two stop bits
        send_capture(2, 8'h55, bc, bits);
        check("odd_bits", 32'(bits[10:0]), 32'(11'b11110101010));
        check("odd_parity_bit", 32'(bits[8]), 32'd1);
        check("odd_busy_len", 32'(bc), 32'd44);

        // Back-to-back frames
        @(negedge clk);
        valid_i[0] = 1'b1; data_i[0] = 8'h01;
        @(negedge clk);
        data_i[0] = 8'h02;
        @(negedge clk);
        data_i[0] = 8'h03;
        @(negedge clk);
        valid_i[0] = 1'b0;
        check("b2b_count_after_pushes", 32'(cnt_o[0]), 32'd2);
        c = 2;
        while (busy_o[0] === 1'b1 && c < 300) begin
            @(negedge clk);
            if (busy_o[0] === 1'b1) c++;
        end
        check("b2b_busy_len", 32'(c), 32'd120);
        wait_idle(0, 50);

        // FIFO full, done twice so the pointers wrap
        for (int fill = 0; fill < 2; fill++) begin
            @(negedge clk);
            valid_i[0] = 1'b1; data_i[0] = 8'h10 + 8'(fill);
            @(negedge clk);
            valid_i[0] = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 17; i++) begin
                valid_i[0] = 1'b1;
                data_i[0]  = (fill == 0) ? (8'h20 + 8'(i)) : (8'hC0 - 8'(i));
                @(negedge clk);
            end
            valid_i[0] = 1'b0;
            check("full_ready_low", 32'(ready_o[0]), 32'd0);
            check("full_count", 32'(cnt_o[0]), 32'd16);
            wait_idle(0, 1000);
        end

        // Push on the edge that ends a frame while one word is queued
        @(negedge clk);
        valid_i[0] = 1'b1; data_i[0] = 8'h3C;
        @(negedge clk);
        data_i[0] = 8'hC3;
        @(negedge clk);
        valid_i[0] = 1'b0;
        repeat (39) @(negedge clk);
        check("simul_count_before", 32'(cnt_o[0]), 32'd1);
        valid_i[0] = 1'b1; data_i[0] = 8'h99;
        @(negedge clk);
        valid_i[0] = 1'b0;
        check("simul_count_after", 32'(cnt_o[0]), 32'd1);
        check("simul_busy", 32'(busy_o[0]), 32'd1);
        check("simul_start_bit", 32'(ser_o[0]), 32'd0);
        wait_idle(0, 200);

        // Reset during data bit 3 of a frame carrying 0x00, with a second word queued
        @(negedge clk);
        valid_i[0] = 1'b1; data_i[0] = 8'h00;
        @(negedge clk);
        data_i[0] = 8'h33;
        @(negedge clk);
        valid_i[0] = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        check("mid_data_bit3_low", 32'(ser_o[0]), 32'd0);
        check("mid_count_before", 32'(cnt_o[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("async_serial", 32'(ser_o[0]), 32'd1);
        check("async_busy", 32'(busy_o[0]), 32'd0);
        check("async_count", 32'(cnt_o[0]), 32'd0);
        check("async_ready", 32'(ready_o[0]), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_busy", 32'(busy_o[0]), 32'd0);
        check("post_reset_serial", 32'(ser_o[0]), 32'd1);

        // A fresh push after the abort transmits normally
        send_capture(0, 8'h5A, bc, bits);
        check("post_reset_bits", 32'(bits[9:0]), 32'(10'b1010110100));
        check("post_reset_busy_len", 32'(bc), 32'd40);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It adds a configurable frame format: data width, parity mode and stop-bit count. It also buffers bytes in an internal FIFO and streams frames back-to-back. It sits between the Z-Modem packet engine, which pushes bytes through a valid/ready interface, and the TX pad.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit; must be >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  word to enqueue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO not full; a push occurs when tx_valid && tx_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO, excluding the frame in flight.
- tx_busy  output  1  a frame is in flight.
- tx_serial  output  1  serial line; idles high.

Behaviour:
- Reset (async assert, sync release):
  - tx_serial=1, tx_busy=0, tx_ready=1, fifo_count=0, state=IDLE.
  - FIFO pointers cleared.
  - Assertion mid-frame aborts the frame immediately: line returns high and all queued data is discarded.
- FIFO:
  - Circular buffer with wrap-around on pointer overflow.
  - tx_ready = (fifo_count != FIFO_DEPTH); it is registered/derived from registered state, never combinational from tx_valid.
  - A push while full is ignored.
  - Push and pop in the same cycle are both legal, including when full (ready is low, so no push) and when at count 1 (net count unchanged).
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_serial=1. If FIFO is non-empty, pop the head into the shift register, set tx_busy=1 and go to START.
  - START: line 0 for CLKS_PER_BIT cycles.
  - DATA: bit[i] for CLKS_PER_BIT cycles each, i = 0..DATA_BITS-1.
  - PARITY: entered only if PARITY != 0. Odd: bit chosen so that the count of ones in data+parity is odd. Even: count is even. Held CLKS_PER_BIT cycles.
  - STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of the last stop-bit cycle:
  - If the FIFO is non-empty: pop on that same edge and go straight to START. No idle gap; tx_busy stays 1.
  - Else: go to IDLE and set tx_busy=0 on that edge.
- Timing:
  - tx_serial is registered.
  - Push at edge E0 into an empty idle block: pop at E1, tx_serial falls after E1.
  - Frame length is exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Widths:
  - The bit counter is sized for DATA_BITS.
  - The baud counter is sized $clog2(CLKS_PER_BIT*2) and must not overflow with STOP_BITS=2.
- Input data changes after a push never affect a queued or in-flight word.

Test Plan:
1. Reset checks (CLKS_PER_BIT=4, defaults): hold reset low, then release. Expect tx_serial=1, tx_ready=1, fifo_count=0, tx_busy=0. Push 0xA5; expect line 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. tx_busy falls exactly 40 cycles after the start edge.
2. Parity: PARITY=2, DATA_BITS=7, push 0x55 -> parity bit 0 (four ones). Same with PARITY=1 -> parity bit 1. Frame is 40 cycles with STOP_BITS=1, 44 with STOP_BITS=2.
3. Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles. Expect three contiguous frames with no idle cycle between the stop bit and the next start bit. tx_busy stays high for 120 cycles; fifo_count reads 2 → 1 → 0 as each word is popped.
4. FIFO full: with the line busy, push 17 words (FIFO_DEPTH=16). Expect tx_ready low after the 16th; the 17th is dropped. All 16 words are transmitted in order, with pointer wrap exercised on a second fill.
5. Simultaneous push and pop: push on the same cycle a frame ends with fifo_count=1. Expect fifo_count to remain 1 and the next frame to carry the older word.
6. Reset mid-frame: assert reset during the DATA bit 3 state. Expect tx_serial=1 within the same cycle (async), the FIFO emptied, and nothing transmitted after release until a new push.
